// File: rtl/rc4_key_sched.sv
// RC4 key-schedule sequencer: steps key_gene through INIT -> KEY_GENE -> EN_DE_CODE and
// streams K[i mod L]. Optional key_gene count cross-check is enabled by RC4_SYNC_CHECK_EN.
module rc4_key_sched #(
  parameter int KEY_MAX   = 16,
  parameter int KSA_STEPS = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_wr_en,
  input  logic [3:0] key_wr_addr,
  input  logic [7:0] key_wr_data,
  input  logic [4:0] key_len,
  input  logic       start,
  input  logic       abort,
  input  logic       data_rready,
  input  logic [8:0] count,
  output logic [1:0] NS,
  output logic [7:0] key_init,
  output logic       busy,
  output logic       done,
  output logic       sync_err
);

  localparam int KIDX_W = $clog2(KEY_MAX);
  localparam int CNT_W  = $clog2(KSA_STEPS);

  localparam logic [1:0] NS_INIT = 2'b00;
  localparam logic [1:0] NS_KSA  = 2'b01;
  localparam logic [1:0] NS_RUN  = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_KSA, S_RUN} state_t;

  state_t              state_q, state_d;
  logic [1:0]          ns_q, ns_d;
  logic [7:0]          key_init_q, key_init_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [KIDX_W-1:0]   len_m1_q, len_m1_d;
  logic [KIDX_W-1:0]   kidx_q, kidx_d;
  logic [CNT_W-1:0]    kcnt_q, kcnt_d;

  logic [7:0]          key_mem [KEY_MAX];
  logic [KIDX_W-1:0]   kidx_nxt;
  logic [KIDX_W-1:0]   len_sel;
  logic                start_acc;

  // Key file has no reset so its contents survive rst; writable only while parked in IDLE
  always_ff @(posedge clk) begin
    if (key_wr_en && (state_q == S_IDLE)) begin
      key_mem[key_wr_addr] <= key_wr_data;
    end
  end

  assign start_acc = start && !abort && ((state_q == S_IDLE) || (state_q == S_RUN));
  assign kidx_nxt  = (kidx_q == len_m1_q) ? '0 : kidx_q + KIDX_W'(1);
  assign len_sel   = ((key_len == 5'd0) || (key_len > 5'(KEY_MAX))) ?
                     KIDX_W'(KEY_MAX - 1) : KIDX_W'(key_len - 5'd1);

  always_comb begin
    state_d    = state_q;
    ns_d       = ns_q;
    key_init_d = key_init_q;
    busy_d     = busy_q;
    done_d     = done_q;
    len_m1_d   = len_m1_q;
    kidx_d     = kidx_q;
    kcnt_d     = kcnt_q;
    if (abort) begin
      state_d    = S_IDLE;
      ns_d       = NS_INIT;
      key_init_d = 8'd0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_RUN: begin
          if (start) begin
            state_d    = S_INIT;
            ns_d       = NS_INIT;
            key_init_d = 8'd0;
            busy_d     = 1'b1;
            done_d     = 1'b0;
            len_m1_d   = len_sel;
          end
        end
        S_INIT: begin
          if (data_rready) begin
            state_d    = S_KSA;
            ns_d       = NS_KSA;
            key_init_d = key_mem[0];
            kidx_d     = '0;
            kcnt_d     = '0;
          end
        end
        S_KSA: begin
          kidx_d     = kidx_nxt;
          key_init_d = key_mem[kidx_nxt];
          kcnt_d     = kcnt_q + CNT_W'(1);
          if (kcnt_q == CNT_W'(KSA_STEPS - 1)) begin
            state_d    = S_RUN;
            ns_d       = NS_RUN;
            key_init_d = 8'd0;
            busy_d     = 1'b0;
            done_d     = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      ns_q       <= NS_INIT;
      key_init_q <= 8'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      len_m1_q   <= '0;
      kidx_q     <= '0;
      kcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      ns_q       <= ns_d;
      key_init_q <= key_init_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      len_m1_q   <= len_m1_d;
      kidx_q     <= kidx_d;
      kcnt_q     <= kcnt_d;
    end
  end

`ifdef RC4_SYNC_CHECK_EN
  logic [CNT_W-1:0] kcnt_dly_q;
  logic             sync_err_q, sync_err_d;
  logic             unused_count_msb;

  // key_gene answers one cycle late, so the first KSA cycle has nothing to compare yet
  always_comb begin
    sync_err_d = sync_err_q;
    if (start_acc) begin
      sync_err_d = 1'b0;
    end else if ((state_q == S_KSA) && (kcnt_q != '0) &&
                 (count[CNT_W-1:0] != kcnt_dly_q)) begin
      sync_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      kcnt_dly_q <= '0;
      sync_err_q <= 1'b0;
    end else begin
      kcnt_dly_q <= kcnt_q;
      sync_err_q <= sync_err_d;
    end
  end

  assign unused_count_msb = ^count[8:CNT_W];
  assign sync_err         = sync_err_q;
`else
  logic unused_count;
  assign unused_count = ^{count, start_acc};
  assign sync_err     = 1'b0;
`endif

  assign NS       = ns_q;
  assign key_init = key_init_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_rc4_key_sched.sv
// Directed bench for rc4_key_sched: key streaming, length handling, abort, async reset,
// dropped writes, and (with RC4_SYNC_CHECK_EN) the sticky sync error.
module tb_rc4_key_sched;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       key_wr_en = 1'b0;
  logic [3:0] key_wr_addr = '0;
  logic [7:0] key_wr_data = '0;
  logic [4:0] key_len = '0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       data_rready = 1'b0;
  logic [8:0] count;
  logic [1:0] NS;
  logic [7:0] key_init;
  logic       busy, done, sync_err;

  logic [8:0] model_k = '0;
  logic [8:0] count_q = '0;
  logic       count_stuck = 1'b0;
  logic [7:0] kv [16];

  int n_chk  = 0;
  int n_pass = 0;

  rc4_key_sched dut (
    .clk(clk), .rst(rst), .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr),
    .key_wr_data(key_wr_data), .key_len(key_len), .start(start), .abort(abort),
    .data_rready(data_rready), .count(count), .NS(NS), .key_init(key_init),
    .busy(busy), .done(done), .sync_err(sync_err)
  );

  always #5 clk = ~clk;

  // key_gene stand-in: step counter that reports with one cycle of latency
  always @(posedge clk) begin
    model_k <= (NS == 2'b01) ? model_k + 9'd1 : 9'd0;
    count_q <= model_k;
  end
  assign count = count_stuck ? 9'd5 : count_q;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr_key(input logic [3:0] a, input logic [7:0] d);
    key_wr_en = 1'b1; key_wr_addr = a; key_wr_data = d;
    tick();
    key_wr_en = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len, input string tag);
    key_len = len; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 32'd1);
    chk({tag, "_start_ns"}, 32'(NS), 32'd0);
  endtask

  task automatic do_abort(input string tag);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk({tag, "_abort_ns"}, 32'(NS), 32'd0);
    chk({tag, "_abort_busy"}, 32'(busy), 32'd0);
    chk({tag, "_abort_done"}, 32'(done), 32'd0);
    chk({tag, "_abort_key"}, 32'(key_init), 32'd0);
  endtask

  task automatic enter_ksa(input string tag);
    data_rready = 1'b0;
    repeat (4) tick();
    chk({tag, "_init_wait_ns"}, 32'(NS), 32'd0);
    data_rready = 1'b1;
    tick();
    data_rready = 1'b0;
  endtask

  task automatic ksa_cycles(input int len, input int n, output int errs, output logic [7:0] last);
    errs = 0;
    last = 8'd0;
    for (int k = 0; k < n; k++) begin
      if ((NS !== 2'b01) || (key_init !== kv[k % len])) errs++;
      last = key_init;
      tick();
    end
  endtask

  task automatic ksa_run(input int len, input string tag, input logic exp_serr,
                         output logic [7:0] last);
    int errs;
    enter_ksa(tag);
    ksa_cycles(len, 256, errs, last);
    chk({tag, "_seq_errs"}, 32'(errs), 32'd0);
    chk({tag, "_run_ns"}, 32'(NS), 32'd2);
    chk({tag, "_run_done"}, 32'(done), 32'd1);
    chk({tag, "_run_busy"}, 32'(busy), 32'd0);
    chk({tag, "_run_key"}, 32'(key_init), 32'd0);
    chk({tag, "_run_serr"}, 32'(sync_err), 32'(exp_serr));
  endtask

  initial begin
    int         errs;
    logic [7:0] last;

    // reset values while rst is held low
    repeat (2) tick();
    chk("rst_ns", 32'(NS), 32'd0);
    chk("rst_key", 32'(key_init), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_serr", 32'(sync_err), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // 1: L=3 key 01 02 03
    kv[0] = 8'h01; kv[1] = 8'h02; kv[2] = 8'h03;
    wr_key(4'd0, 8'h01); wr_key(4'd1, 8'h02); wr_key(4'd2, 8'h03);
    do_start(5'd3, "t1");
    ksa_run(3, "t1", 1'b0, last);

    // 5: write in S_RUN and during S_INIT both dropped; rekey straight from S_RUN
    wr_key(4'd0, 8'hFF);
    do_start(5'd3, "t5");
    chk("t5_rekey_done", 32'(done), 32'd0);
    wr_key(4'd0, 8'hFF);
    ksa_run(3, "t5", 1'b0, last);

    // 2: L=0 -> 16-byte key 00..0F
    do_abort("t2pre");
    for (int i = 0; i < 16; i++) begin
      kv[i] = 8'(i);
      wr_key(4'(i), 8'(i));
    end
    do_start(5'd0, "t2");
    ksa_run(16, "t2", 1'b0, last);
    chk("t2_last_byte", 32'(last), 32'h0F);

    // 3: abort at KSA cycle 100, then restart from K[0]
    do_abort("t3pre");
    kv[0] = 8'hA5;
    wr_key(4'd0, 8'hA5);
    do_start(5'd7, "t3");
    enter_ksa("t3");
    ksa_cycles(7, 100, errs, last);
    chk("t3_pre_abort_errs", 32'(errs), 32'd0);
    do_abort("t3");
    do_start(5'd7, "t3b");
    ksa_run(7, "t3b", 1'b0, last);

    // 4: asynchronous reset mid-KSA; key file survives
    do_start(5'd7, "t4");
    enter_ksa("t4");
    ksa_cycles(7, 50, errs, last);
    rst = 1'b0;
    #2;
    chk("t4_async_ns", 32'(NS), 32'd0);
    chk("t4_async_busy", 32'(busy), 32'd0);
    chk("t4_async_key", 32'(key_init), 32'd0);
    chk("t4_async_done", 32'(done), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    do_start(5'd7, "t4b");
    ksa_run(7, "t4b", 1'b0, last);

    // L=1 holds K[0]; L>16 clamps to 16
    do_start(5'd1, "tl1");
    ksa_run(1, "tl1", 1'b0, last);
    do_start(5'd20, "tl20");
    ksa_run(16, "tl20", 1'b0, last);
    chk("tl20_last_byte", 32'(last), 32'h0F);

`ifdef RC4_SYNC_CHECK_EN
    // 6: stuck count sets sticky sync_err; abort keeps it, accepted start clears it
    count_stuck = 1'b1;
    do_start(5'd3, "t6");
    ksa_run(3, "t6", 1'b1, last);
    count_stuck = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("t6_serr_kept", 32'(sync_err), 32'd1);
    do_start(5'd3, "t6b");
    chk("t6_serr_cleared", 32'(sync_err), 32'd0);
    ksa_run(3, "t6b", 1'b0, last);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
